icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
Parametrised direct-mapped instruction cache between the RISC-V fetch stage and the instruction memory port. It serves hits in the same cycle from on-chip tag/data arrays. On a miss it stalls the CPU and refills one full line word-by-word over the strobe/ready memory handshake. This generalises the single-word pass-through fetch path to configurable line count and line size, with a flush capability.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, instruction/data word width in bits
LINES, 16, number of cache lines (power of 2, >=2)
WORDS_PER_LINE, 4, words per line (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
I_addr  input  ADDR_W  CPU fetch byte address; bits [1:0] ignored
IM_enable  input  1  fetch request this cycle
flush  input  1  invalidate all lines
IM_out  output  DATA_W  fetched instruction
stall  output  1  CPU must hold the PC
P_strobe  output  1  memory read request
P_addr  output  ADDR_W  memory word address (byte address, 4-aligned)
P_data  input  DATA_W  memory read data
P_ready  input  1  memory data valid / request accepted
P_rw  output  1  constant 1 (read)
hit_cnt  output  32  hit counter (ICACHE_STATS_EN only)
miss_cnt  output  32  miss counter (ICACHE_STATS_EN only)

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE) word-select bits above [1:0]; IDX = log2(LINES) bits above that; TAG = remaining upper bits.
- Storage: valid[LINES] as flops; tag and data arrays read asynchronously and written on clk.
- hit = valid[idx] & (tag[idx] == I_addr tag), with state == IDLE.
- FSM states:
  - IDLE: if IM_enable & !hit & !flush, latch line base (I_addr with OFF and byte bits cleared) and go to REFILL with k=0.
  - REFILL: P_strobe=1, P_addr = base + 4*k. On P_ready, write P_data into data[idx][k]. If k==WORDS_PER_LINE-1, set tag and valid and go to IDLE; else k++.
- stall (combinational) = IM_enable & (state != IDLE | !hit). stall is 0 when IM_enable=0.
- IM_out (combinational) = data[idx][word] when IM_enable & hit & IDLE; otherwise 32'h00000013 (NOP).
- Hit latency is 0 cycles. Miss penalty is WORDS_PER_LINE handshakes plus 1 lookup cycle; the hit appears in the cycle after returning to IDLE.
- P_rw is always 1. P_strobe is 0 in IDLE. P_addr holds its last value while in IDLE.
- I_addr changing mid-refill: the refill completes for the latched line, then the new address is looked up.
- IM_enable dropping mid-refill: the refill continues to completion.
- flush: clears all valid bits in one cycle. If asserted in IDLE, no refill starts that cycle. If asserted during REFILL (or on the final-word cycle), the refill finishes but the line is NOT marked valid (flush wins).
- Reset:
  - state = IDLE, all valid = 0, k = 0.
  - P_strobe = 0, P_addr = 0, P_rw = 1.
  - IM_out = 32'h13. stall = IM_enable (since every lookup misses).
  - Counters = 0.
  - rst mid-refill aborts the refill; the partially filled line stays invalid.

Optional Feature:
ICACHE_STATS_EN
- Defined: hit_cnt and miss_cnt ports exist. hit_cnt increments each cycle with IM_enable & hit & IDLE. miss_cnt increments once per IDLE→REFILL transition. Both wrap at 2^32 and reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then IM_enable=1, I_addr=0x100, memory returns 0xA0+k after 2-cycle P_ready latency → P_addr sequence 0x100, 0x104, 0x108, 0x10C; stall=1 throughout; next cycle IM_out=0xA0, stall=0.
- After that fill, fetch 0x104, 0x108, 0x10C → same-cycle hits, IM_out=0xA1, 0xA2, 0xA3, stall=0, no P_strobe.
- Fetch 0x500 (same index as 0x100, different tag) → refill, line replaced; refetch 0x100 → miss again.
- flush pulse during the third refill word of 0x200 → refill completes; next fetch of 0x200 misses and refills again.
- IM_enable=0 for 3 cycles while idle → stall=0, IM_out=0x13, P_strobe=0; rst asserted mid-refill → P_strobe=0 next cycle, line invalid.
- ICACHE_STATS_EN: 1 miss plus 3 hits → miss_cnt=1, hit_cnt=3.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with line refill over a strobe/ready port.
// Optional ICACHE_STATS_EN adds hit_cnt/miss_cnt counters and ports.
module icache_dm #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic              IM_enable,
    input  logic              flush,
    output logic [DATA_W-1:0] IM_out,
    output logic              stall,
    output logic              P_strobe,
    output logic [ADDR_W-1:0] P_addr,
    input  logic [DATA_W-1:0] P_data,
    input  logic              P_ready,
    output logic              P_rw
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int LA_W  = ADDR_W - 2 - OFF_W;
    localparam int TAG_W = LA_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_K = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic {IDLE, REFILL} state_e;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  k_q, k_d;
    logic [LA_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              flushed_q, flushed_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES*WORDS_PER_LINE];

    logic [OFF_W-1:0]  a_off;
    logic [IDX_W-1:0]  a_idx;
    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic [ADDR_W-1:0] refill_addr;
    logic              hit;
    logic              wr_en;
    logic [1:0]        unused_byte;

    assign a_off       = I_addr[2+:OFF_W];
    assign a_idx       = I_addr[2+OFF_W+:IDX_W];
    assign a_tag       = I_addr[ADDR_W-1-:TAG_W];
    assign unused_byte = I_addr[1:0];
    assign r_idx       = base_q[0+:IDX_W];
    assign r_tag       = base_q[LA_W-1-:TAG_W];
    assign refill_addr = {base_q, k_q, 2'b00};

    assign hit   = (state_q == IDLE) && valid_q[a_idx]
                   && (tag_q[a_idx] == a_tag);
    assign wr_en = (state_q == REFILL) && P_ready;

    assign stall    = IM_enable & ~hit;
    assign IM_out   = (IM_enable && hit) ? data_q[{a_idx, a_off}]
                                         : DATA_W'(32'h0000_0013);
    assign P_strobe = (state_q == REFILL);
    assign P_addr   = (state_q == REFILL) ? refill_addr : paddr_q;
    assign P_rw     = 1'b1;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        paddr_d   = paddr_q;
        flushed_d = flushed_q;
        valid_d   = valid_q;
        if (flush) valid_d = '0;
        unique case (state_q)
            IDLE: begin
                if (IM_enable && !hit && !flush) begin
                    state_d   = REFILL;
                    k_d       = '0;
                    base_d    = I_addr[ADDR_W-1:2+OFF_W];
                    flushed_d = 1'b0;
                end
            end
            REFILL: begin
                paddr_d = refill_addr;
                if (flush) flushed_d = 1'b1;
                if (P_ready) begin
                    if (k_q == LAST_K) begin
                        state_d = IDLE;
                        k_d     = '0;
                        // a flush seen anywhere in the refill leaves it invalid
                        if (!flush && !flushed_q) valid_d[r_idx] = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            base_q    <= '0;
            paddr_q   <= '0;
            flushed_q <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            paddr_q   <= paddr_d;
            flushed_q <= flushed_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{r_idx, k_q}] <= P_data;
            if (k_q == LAST_K) tag_q[r_idx] <= r_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (IM_enable && hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && state_d == REFILL)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a 2-cycle-latency memory responder.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] I_addr;
    logic        IM_enable;
    logic        flush;
    logic [31:0] IM_out;
    logic        stall;
    logic        P_strobe;
    logic [31:0] P_addr;
    logic [31:0] P_data = '0;
    logic        P_ready = 1'b0;
    logic        P_rw;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int acc_cnt = 0;
    int lat_cnt = 0;
    logic [31:0] addr_log [$];

    icache_dm dut (
        .clk       (clk),
        .rst       (rst),
        .I_addr    (I_addr),
        .IM_enable (IM_enable),
        .flush     (flush),
        .IM_out    (IM_out),
        .stall     (stall),
        .P_strobe  (P_strobe),
        .P_addr    (P_addr),
        .P_data    (P_data),
        .P_ready   (P_ready),
        .P_rw      (P_rw)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // memory: word at a = A0 + word offset + (a - 0x100) line part
    always @(negedge clk) begin
        if (!P_strobe || P_ready) begin
            P_ready = 1'b0;
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt == 2) begin
                P_ready = 1'b1;
                P_data  = 32'hA0 + 32'(P_addr[3:2])
                          + ((P_addr - 32'h100) & ~32'hF);
                acc_cnt++;
                addr_log.push_back(P_addr);
                lat_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_fill();
        int n = 0;
        while (stall && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        chk("fill_done", {31'd0, stall}, 32'd0);
    endtask

    task automatic fetch_miss(input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        I_addr = a; IM_enable = 1'b1;
        #2;
        chk("miss_stall", {31'd0, stall}, 32'd1);
        wait_fill();
        chk("miss_data", IM_out, exp);
    endtask

    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        I_addr = a; IM_enable = 1'b1;
        #2;
        chk("hit_stall", {31'd0, stall}, 32'd0);
        chk("hit_data", IM_out, exp);
        chk("hit_strobe", {31'd0, P_strobe}, 32'd0);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        chk("acc_wait", 32'(acc_cnt >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst = 1'b1; IM_enable = 1'b0; flush = 1'b0; I_addr = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_out", IM_out, 32'h13);
        chk("rst_strobe", {31'd0, P_strobe}, 32'd0);
        chk("rst_paddr", P_addr, 32'h0);
        chk("rst_rw", {31'd0, P_rw}, 32'd1);
`ifdef ICACHE_STATS_EN
        chk("rst_hits", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
`endif
        IM_enable = 1'b1; I_addr = 32'h100;
        #1;
        chk("rst_stall_en", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst = 1'b0; IM_enable = 1'b0;

        // first fill of line 0x100
        addr_log.delete();
        fetch_miss(32'h100, 32'hA0);
        chk("fill_len", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("fill_addr", addr_log[i], 32'h100 + 32'(4 * i));
        chk("paddr_hold", P_addr, 32'h10C);

        fetch_hit(32'h104, 32'hA1);
        fetch_hit(32'h108, 32'hA2);
        fetch_hit(32'h10C, 32'hA3);

        // conflicting tag on index 0 evicts 0x100
        fetch_miss(32'h500, 32'h4A0);
        fetch_hit(32'h50C, 32'h4A3);
        fetch_miss(32'h100, 32'hA0);

        // flush during third word of 0x200: refill repeats
        @(negedge clk);
        start = acc_cnt;
        I_addr = 32'h200; IM_enable = 1'b1;
        wait_acc(start + 2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        wait_fill();
        chk("flush_words", 32'(acc_cnt - start), 32'd8);
        chk("flush_data", IM_out, 32'h1A0);
        fetch_hit(32'h204, 32'h1A1);

        // idle flush invalidates
        @(negedge clk);
        IM_enable = 1'b0; flush = 1'b1;
        #2;
        chk("idle_flush_strobe", {31'd0, P_strobe}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        fetch_miss(32'h208, 32'h1A2);

        // idle with no request
        @(negedge clk);
        IM_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_out", IM_out, 32'h13);
            chk("idle_strobe", {31'd0, P_strobe}, 32'd0);
        end

        // reset in the middle of a refill
        @(negedge clk);
        start = acc_cnt;
        I_addr = 32'h300; IM_enable = 1'b1;
        wait_acc(start + 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_mid_strobe", {31'd0, P_strobe}, 32'd0);
        chk("rst_mid_miss", {31'd0, stall}, 32'd1);
        wait_fill();
        chk("rst_mid_data", IM_out, 32'h2A0);

`ifdef ICACHE_STATS_EN
        @(negedge clk);
        rst = 1'b1; IM_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fetch_miss(32'h100, 32'hA0);
        fetch_hit(32'h104, 32'hA1);
        fetch_hit(32'h108, 32'hA2);
        @(negedge clk);
        IM_enable = 1'b0;
        #2;
        chk("stat_miss", miss_cnt, 32'd1);
        chk("stat_hits", hit_cnt, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
